apb2axi_txn_router: RTL and testbench

// - Multi-source successor to the single-source transaction manager. Sits in the AXI clock domain between
//   NUM_SRC committed-directory pop ports and the WR/RD request FIFOs.
// - Round-robin arbitrates the sources and registers each routed entry in a per-direction skid buffer.
// - Enforces read-after-write ordering: a read waits while an overlapping write is still outstanding on AXI.

---
 rtl/apb2axi_txn_router_pkg.sv | 18 +
 rtl/apb2axi_txn_router_if.sv | 29 ++
 rtl/apb2axi_txn_router_skid_buf.sv | 48 ++++
 rtl/apb2axi_txn_router.sv | 128 ++++++++++++
 tb/tb_apb2axi_txn_router.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb2axi_txn_router_pkg.sv
// Shared types for the multi-source directory-to-AXI-FIFO router.
// The directory entry layout is the contract between the APB side and the AXI request FIFOs.
package apb2axi_txn_router_pkg;

    localparam int ADDR_W        = 32;
    localparam int TRK_DEPTH_DEF = 4;
    localparam int HAZ_LSB_DEF   = 6;

    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [3:0]        id;
    } directory_entry_t;

    localparam int CMD_ENTRY_W = $bits(directory_entry_t);

endpackage

// File: rtl/apb2axi_txn_router_if.sv
// Source pop ports plus WR/RD FIFO push ports of the router.
// The router owns the slave view; whatever drives the sources and sinks the FIFOs owns the master view.
interface apb2axi_txn_router_if
    import apb2axi_txn_router_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int ENTRY_W = CMD_ENTRY_W
);
    logic [NUM_SRC-1:0]              src_vld;
    logic [NUM_SRC-1:0][ENTRY_W-1:0] src_entry;
    logic [NUM_SRC-1:0]              src_rdy;
    logic                            wr_push_vld;
    logic                            wr_push_rdy;
    logic [ENTRY_W-1:0]              wr_push_data;
    logic                            rd_push_vld;
    logic                            rd_push_rdy;
    logic [ENTRY_W-1:0]              rd_push_data;

    modport slave (
        input  src_vld, src_entry, wr_push_rdy, rd_push_rdy,
        output src_rdy, wr_push_vld, wr_push_data, rd_push_vld, rd_push_data
    );

    modport master (
        output src_vld, src_entry, wr_push_rdy, rd_push_rdy,
        input  src_rdy, wr_push_vld, wr_push_data, rd_push_vld, rd_push_data
    );

endinterface

// File: rtl/apb2axi_txn_router_skid_buf.sv
// Small valid/ready FIFO feeding one AXI request FIFO; output held stable until rdy_i.
// The caller only pushes when full_o is low, so no overflow guard is needed here.
module apb2axi_txn_router_skid_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         vld_o,
    input  logic         rdy_i,
    output logic [W-1:0] dout_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          pop;

    assign pop    = vld_o && rdy_i;
    assign vld_o  = (cnt_q != '0);
    assign full_o = (cnt_q == (AW+1)'(DEPTH));
    assign dout_o = mem_q[rp_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= (wp_q == AW'(DEPTH-1)) ? '0 : wp_q + 1'b1;
            end
            if (pop) rp_q <= (rp_q == AW'(DEPTH-1)) ? '0 : rp_q + 1'b1;
            case ({push_i, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/apb2axi_txn_router.sv
// Round-robin router from NUM_SRC directory pop ports into WR/RD skid buffers, holding
// back reads that overlap a write still outstanding on AXI (tracked from accept until B).
module apb2axi_txn_router
    import apb2axi_txn_router_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int ENTRY_W   = CMD_ENTRY_W,
    parameter int TRK_DEPTH = TRK_DEPTH_DEF,
    parameter int HAZ_LSB   = HAZ_LSB_DEF,
    parameter bit HAZARD_EN = 1'b1,
    localparam int CNT_W    = $clog2(TRK_DEPTH) + 1
) (
    input  logic                 aclk_i,
    input  logic                 areset_i,
    apb2axi_txn_router_if.slave  bus,
    input  logic                 wr_done_vld_i,
    output logic [CNT_W-1:0]     trk_count_o,
    output logic                 haz_stall_o,
    output logic                 wr_done_err_o
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W = $clog2(TRK_DEPTH);
    localparam int TAG_W = ADDR_W - HAZ_LSB;

    directory_entry_t [NUM_SRC-1:0] ent;
    directory_entry_t               sel;
    logic [NUM_SRC-1:0]             elig, haz_hit, rd_blk;
    logic [SRC_W-1:0]               rr_q, rr_d, gnt_idx, cand;
    logic                           gnt_vld, wr_push, rd_push, wr_full, rd_full, alloc, free, err_q;
    logic [PTR_W:0]                 wr_ptr_q, rd_ptr_q;
    logic [TAG_W-1:0]               tag_q [TRK_DEPTH];
    logic [TRK_DEPTH-1:0]           slot_vld;
    logic [CNT_W-1:0]               cnt;

    assign cnt = wr_ptr_q - rd_ptr_q;

    // A slot is live when its distance from the oldest entry is below the occupancy.
    for (genvar j = 0; j < TRK_DEPTH; j++) begin : g_slot
        logic [PTR_W-1:0] off;
        assign off         = PTR_W'(j) - rd_ptr_q[PTR_W-1:0];
        assign slot_vld[j] = ({1'b0, off} < cnt);
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [TRK_DEPTH-1:0] match;
        assign ent[i] = bus.src_entry[i];
        for (genvar j = 0; j < TRK_DEPTH; j++) begin : g_cmp
            assign match[j] = slot_vld[j] && (tag_q[j] == ent[i].addr[ADDR_W-1:HAZ_LSB]);
        end
        assign haz_hit[i] = HAZARD_EN && (|match);
        assign rd_blk[i]  = bus.src_vld[i] && !ent[i].is_write && haz_hit[i];
        assign elig[i]    = bus.src_vld[i] && !areset_i &&
                            (ent[i].is_write ? (!wr_full && (cnt < CNT_W'(TRK_DEPTH)))
                                             : (!rd_full && !haz_hit[i]));
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = SRC_W'((int'(rr_q) + k) % NUM_SRC);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        bus.src_rdy = '0;
        if (gnt_vld) bus.src_rdy[gnt_idx] = 1'b1;
    end

    assign sel     = ent[gnt_idx];
    assign rr_d    = (gnt_idx == SRC_W'(NUM_SRC-1)) ? '0 : gnt_idx + 1'b1;
    assign wr_push = gnt_vld && sel.is_write;
    assign rd_push = gnt_vld && !sel.is_write;
    assign alloc   = wr_push;
    assign free    = wr_done_vld_i && (cnt != '0);

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (gnt_vld) rr_q <= rr_d;
            if (alloc)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (free)    rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_done_vld_i && (cnt == '0)) err_q <= 1'b1;
        end
    end

    // Tags need no reset: slot validity comes purely from the pointers.
    always_ff @(posedge aclk_i) begin
        if (alloc) tag_q[wr_ptr_q[PTR_W-1:0]] <= sel.addr[ADDR_W-1:HAZ_LSB];
    end

    apb2axi_txn_router_skid_buf #(.W(ENTRY_W), .DEPTH(2)) u_wr_skid (
        .clk_i  (aclk_i),
        .rst_i  (areset_i),
        .push_i (wr_push),
        .din_i  (bus.src_entry[gnt_idx]),
        .full_o (wr_full),
        .vld_o  (bus.wr_push_vld),
        .rdy_i  (bus.wr_push_rdy),
        .dout_o (bus.wr_push_data)
    );

    apb2axi_txn_router_skid_buf #(.W(ENTRY_W), .DEPTH(2)) u_rd_skid (
        .clk_i  (aclk_i),
        .rst_i  (areset_i),
        .push_i (rd_push),
        .din_i  (bus.src_entry[gnt_idx]),
        .full_o (rd_full),
        .vld_o  (bus.rd_push_vld),
        .rdy_i  (bus.rd_push_rdy),
        .dout_o (bus.rd_push_data)
    );

    assign trk_count_o   = cnt;
    assign haz_stall_o   = |rd_blk;
    assign wr_done_err_o = err_q;

endmodule

// File: tb/tb_apb2axi_txn_router.sv
// Router bench: directed scenarios plus random traffic, every cycle compared against a
// queue-based model of the skid buffers, outstanding-write list and round-robin pointer.
module tb_apb2axi_txn_router;
    import apb2axi_txn_router_pkg::*;

    localparam int NS = 2;
    localparam int D  = TRK_DEPTH_DEF;
    localparam int HL = HAZ_LSB_DEF;
    localparam int CW = $clog2(D) + 1;

    logic          aclk    = 1'b0;
    logic          areset  = 1'b1;
    logic          wr_done = 1'b0;
    logic [CW-1:0] trk_count;
    logic          haz_stall, wr_done_err;
    int            total = 0, bad = 0;

    apb2axi_txn_router_if #(.NUM_SRC(NS), .ENTRY_W(CMD_ENTRY_W)) bus ();

    apb2axi_txn_router #(
        .NUM_SRC(NS), .ENTRY_W(CMD_ENTRY_W), .TRK_DEPTH(D), .HAZ_LSB(HL), .HAZARD_EN(1'b1)
    ) dut (
        .aclk_i        (aclk),
        .areset_i      (areset),
        .bus           (bus.slave),
        .wr_done_vld_i (wr_done),
        .trk_count_o   (trk_count),
        .haz_stall_o   (haz_stall),
        .wr_done_err_o (wr_done_err)
    );

    always #5 aclk = ~aclk;

    directory_entry_t  wq[$], rq[$];
    logic [ADDR_W-1:0] trk[$];
    int                rr = 0;
    bit                err_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic bit hazard(input logic [ADDR_W-1:0] a);
        foreach (trk[j]) if ((trk[j] >> HL) == (a >> HL)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic directory_entry_t mk(input bit w, input logic [ADDR_W-1:0] a);
        directory_entry_t e;
        e.is_write = w;
        e.addr     = a;
        e.len      = 8'($urandom);
        e.id       = 4'($urandom);
        return e;
    endfunction

    function automatic directory_entry_t rnd_entry();
        return mk(1'($urandom_range(1)), 32'h1000 + 32'($urandom_range(3)) * 64 + 32'($urandom_range(63)));
    endfunction

    // One cycle: compare DUT against the model at negedge, advance the model, then clock.
    task automatic step(output int g, output logic [NS-1:0] seen);
        logic [NS-1:0]    exp_rdy;
        bit               hz;
        directory_entry_t e;
        @(negedge aclk);
        g  = -1;
        hz = 1'b0;
        for (int k = 0; k < NS; k++) begin
            int i;
            bit ok;
            i  = (rr + k) % NS;
            e  = bus.src_entry[i];
            ok = bus.src_vld[i] && (e.is_write ? (wq.size() < 2 && trk.size() < D)
                                               : (rq.size() < 2 && !hazard(e.addr)));
            if (g < 0 && ok) g = i;
        end
        for (int i = 0; i < NS; i++) begin
            e = bus.src_entry[i];
            if (bus.src_vld[i] && !e.is_write && hazard(e.addr)) hz = 1'b1;
        end
        exp_rdy = (g >= 0) ? NS'(1 << g) : '0;
        seen    = bus.src_rdy;
        chk("src_rdy", bus.src_rdy, exp_rdy);
        chk("wr_vld", bus.wr_push_vld, wq.size() > 0);
        if (wq.size() > 0) chk("wr_data", bus.wr_push_data, wq[0]);
        chk("rd_vld", bus.rd_push_vld, rq.size() > 0);
        if (rq.size() > 0) chk("rd_data", bus.rd_push_data, rq[0]);
        chk("trk_count", trk_count, trk.size());
        chk("haz_stall", haz_stall, hz);
        chk("done_err", wr_done_err, err_m);
        if (wq.size() > 0 && bus.wr_push_rdy) void'(wq.pop_front());
        if (rq.size() > 0 && bus.rd_push_rdy) void'(rq.pop_front());
        if (wr_done) begin
            if (trk.size() > 0) void'(trk.pop_front());
            else err_m = 1'b1;
        end
        if (g >= 0) begin
            e = bus.src_entry[g];
            if (e.is_write) begin
                wq.push_back(e);
                trk.push_back(e.addr);
            end else rq.push_back(e);
            rr = (g + 1) % NS;
        end
        @(posedge aclk);
        #1;
        if (g >= 0) bus.src_vld[g] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        areset = 1'b1;
        wq.delete(); rq.delete(); trk.delete();
        rr = 0; err_m = 1'b0;
        repeat (n) begin
            @(negedge aclk);
            chk("rst_rdy", bus.src_rdy, 0);
            chk("rst_wvld", bus.wr_push_vld, 0);
            chk("rst_rvld", bus.rd_push_vld, 0);
            chk("rst_wdata", bus.wr_push_data, 0);
            chk("rst_rdata", bus.rd_push_data, 0);
            chk("rst_cnt", trk_count, 0);
            chk("rst_haz", haz_stall, 0);
            chk("rst_err", wr_done_err, 0);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic drain();
        int            g, n;
        logic [NS-1:0] s;
        bus.src_vld = '0;
        bus.wr_push_rdy = 1'b1;
        bus.rd_push_rdy = 1'b1;
        n = 0;
        while ((wq.size() + rq.size() + trk.size()) > 0 && n < 40) begin
            wr_done = (trk.size() > 0);
            step(g, s);
            n++;
        end
        wr_done = 1'b0;
        chk("drain_timeout", n < 40, 1);
    endtask

    initial begin
        int            g, nacc;
        logic [NS-1:0] s;
        bus.src_vld = '0;
        bus.src_entry = '0;
        bus.wr_push_rdy = 1'b1;
        bus.rd_push_rdy = 1'b1;

        // reset with both sources requesting, then src0 wins first
        bus.src_entry[0] = mk(1'b0, 32'h0100);
        bus.src_entry[1] = mk(1'b0, 32'h0200);
        bus.src_vld = 2'b11;
        do_reset(3);
        step(g, s);
        chk("first_gnt", s, 2'b01);

        // both sources streaming reads alternate
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NS; i++)
                if (!bus.src_vld[i]) begin
                    bus.src_entry[i] = mk(1'b0, 32'h0400 + 32'(k * 128 + i * 64));
                    bus.src_vld[i] = 1'b1;
                end
            step(g, s);
            chk("rr_alt", s, (k % 2 == 0) ? 2'b10 : 2'b01);
        end

        // read-after-write hazard in the same 64B granule
        drain();
        bus.src_entry[0] = mk(1'b1, 32'h1000); bus.src_vld[0] = 1'b1;
        step(g, s);
        bus.src_entry[1] = mk(1'b0, 32'h1020); bus.src_vld[1] = 1'b1;
        step(g, s);
        chk("raw_hold", s, 2'b00);
        chk("raw_stall", haz_stall, 1);
        wr_done = 1'b1;
        step(g, s);
        chk("raw_done_cyc", s, 2'b00);
        wr_done = 1'b0;
        step(g, s);
        chk("raw_release", s, 2'b10);
        bus.src_entry[0] = mk(1'b1, 32'h1000); bus.src_vld[0] = 1'b1;
        step(g, s);
        bus.src_entry[1] = mk(1'b0, 32'h1040); bus.src_vld[1] = 1'b1;
        step(g, s);
        chk("other_granule", s, 2'b10);

        // blocked read must not hold up a write from the other source
        drain();
        bus.src_entry[1] = mk(1'b1, 32'h1000); bus.src_vld[1] = 1'b1;
        step(g, s);
        bus.src_entry[0] = mk(1'b0, 32'h1000); bus.src_vld[0] = 1'b1;
        bus.src_entry[1] = mk(1'b1, 32'h2000); bus.src_vld[1] = 1'b1;
        step(g, s);
        chk("skip_blk", s, 2'b10);
        chk("trk2", trk_count, 2);

        // WR backpressure: only two writes fit, reads keep flowing
        drain();
        bus.wr_push_rdy = 1'b0;
        nacc = 0;
        for (int k = 0; k < 6; k++) begin
            if (!bus.src_vld[0]) begin bus.src_entry[0] = mk(1'b1, 32'h3000 + 32'(k * 64)); bus.src_vld[0] = 1'b1; end
            if (!bus.src_vld[1]) begin bus.src_entry[1] = mk(1'b0, 32'h5000 + 32'(k * 64)); bus.src_vld[1] = 1'b1; end
            step(g, s);
            if (s[0]) nacc++;
        end
        chk("bp_wacc", nacc, 2);
        drain();

        // tracker full, same-cycle alloc+free, and the sticky error
        nacc = 0;
        for (int k = 0; k < 10 && nacc < 4; k++) begin
            if (!bus.src_vld[0]) begin bus.src_entry[0] = mk(1'b1, 32'h8000 + 32'(k * 64)); bus.src_vld[0] = 1'b1; end
            step(g, s);
            if (s[0]) nacc++;
        end
        bus.src_entry[0] = mk(1'b1, 32'h9000); bus.src_vld[0] = 1'b1;
        step(g, s);
        chk("full_stall", s, 2'b00);
        chk("full_cnt", trk_count, 4);
        wr_done = 1'b1;
        step(g, s);
        chk("full_free_cyc", s, 2'b00);
        step(g, s);
        chk("alloc_free", s, 2'b01);
        wr_done = 1'b0;
        chk("cnt_same", trk_count, 3);
        drain();
        wr_done = 1'b1;
        step(g, s);
        wr_done = 1'b0;
        chk("err_set", wr_done_err, 1);
        step(g, s);
        chk("err_sticky", wr_done_err, 1);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NS; i++)
                if (!bus.src_vld[i] && $urandom_range(3) != 0) begin
                    bus.src_entry[i] = rnd_entry();
                    bus.src_vld[i] = 1'b1;
                end
            bus.wr_push_rdy = ($urandom_range(3) != 0);
            bus.rd_push_rdy = ($urandom_range(3) != 0);
            wr_done = (trk.size() > 0) && ($urandom_range(1) == 1);
            step(g, s);
        end
        wr_done = 1'b0;

        // mid-operation reset drops everything, then traffic resumes
        do_reset(2);
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < NS; i++)
                if (!bus.src_vld[i]) begin bus.src_entry[i] = rnd_entry(); bus.src_vld[i] = 1'b1; end
            bus.wr_push_rdy = 1'b1;
            bus.rd_push_rdy = 1'b1;
            wr_done = (trk.size() > 0) && ($urandom_range(1) == 1);
            step(g, s);
        end
        wr_done = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
